// File: rtl/mmio_fifo_regs.sv
// mmio_fifo_regs: MMIO register block with a device feature header, a 128-bit AFU ID,
// NUM_REGS 64-bit scratch registers and a 64-bit FIFO reached through one
// push/pop address.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   mmio_wr_valid   write strobe (mmio_addr, mmio_wdata)
//   mmio_rd_valid   read strobe (mmio_addr, mmio_tid)
//   mmio_addr       16-bit DWORD address shared by reads and writes
//   mmio_tid        read transaction ID, echoed on the response
//   mmio_wdata      64-bit write data
//   rd_rsp_valid    one-cycle read response strobe, one cycle after mmio_rd_valid
//   rd_rsp_tid      echoed transaction ID
//   rd_rsp_data     64-bit read data
//
// Build option: define MMIO_FIFO_STATUS_EN to add a status register at FIFO_ADDR+2
// holding the FIFO count and sticky overflow/underflow flags (write 1 to clear).
// Without it that address is unmapped and the flags do not exist.

module mmio_fifo_regs #(
  parameter int unsigned    NUM_REGS   = 4,
  parameter int unsigned    FIFO_DEPTH = 16,
  parameter logic [15:0]    FIFO_ADDR  = 16'h0040,
  parameter logic [127:0]   AFU_ID     = 128'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mmio_wr_valid,
  input  logic        mmio_rd_valid,
  input  logic [15:0] mmio_addr,
  input  logic [8:0]  mmio_tid,
  input  logic [63:0] mmio_wdata,
  output logic        rd_rsp_valid,
  output logic [8:0]  rd_rsp_tid,
  output logic [63:0] rd_rsp_data
);

  localparam int unsigned    AW          = $clog2(FIFO_DEPTH);
  localparam int unsigned    CW          = AW + 1;
  localparam logic [CW-1:0]  FULL_COUNT  = CW'(FIFO_DEPTH);
  localparam logic [15:0]    STATUS_ADDR = FIFO_ADDR + 16'd2;
  localparam logic [63:0]    DFH         = {4'b0001, 8'b0, 4'b0, 7'b0, 1'b1, 24'b0, 4'b0, 12'b0};

  logic [63:0]   r_regs [NUM_REGS];
  logic [63:0]   r_mem  [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic          r_rsp_valid;
  logic [8:0]    r_rsp_tid;
  logic [63:0]   r_rsp_data;

  logic          w_fifo_wr;
  logic          w_fifo_rd;
  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic [63:0]   w_rd_data;

  assign w_fifo_wr = mmio_wr_valid && (mmio_addr == FIFO_ADDR);
  assign w_fifo_rd = mmio_rd_valid && (mmio_addr == FIFO_ADDR);
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == FULL_COUNT);
  assign w_pop     = w_fifo_rd && !w_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_push    = w_fifo_wr && (!w_full || w_pop);

`ifdef MMIO_FIFO_STATUS_EN
  logic r_ovf;
  logic r_unf;
  logic w_ovf_set;
  logic w_unf_set;
  logic w_stat_wr;

  assign w_ovf_set = w_fifo_wr && !w_push;
  assign w_unf_set = w_fifo_rd && w_empty;
  assign w_stat_wr = mmio_wr_valid && (mmio_addr == STATUS_ADDR);

  // A new event in the same cycle as a clear wins, so no event is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= (r_ovf && !(w_stat_wr && mmio_wdata[16])) || w_ovf_set;
      r_unf <= (r_unf && !(w_stat_wr && mmio_wdata[17])) || w_unf_set;
    end
  end
`endif

  // Read data is built from current state, so a same-cycle write is not visible.
  always_comb begin
    w_rd_data = '0;
    case (mmio_addr)
      16'h0000: w_rd_data = DFH;
      16'h0002: w_rd_data = AFU_ID[63:0];
      16'h0004: w_rd_data = AFU_ID[127:64];
      default:  w_rd_data = '0;
    endcase
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (mmio_addr == 16'(32 + 2 * i)) w_rd_data = r_regs[i];
    end
    if (mmio_addr == FIFO_ADDR) w_rd_data = w_empty ? '0 : r_mem[r_rptr];
`ifdef MMIO_FIFO_STATUS_EN
    if (mmio_addr == STATUS_ADDR) w_rd_data = {46'b0, r_unf, r_ovf, 16'(r_count)};
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) r_regs[i] <= '0;
    end else if (mmio_wr_valid) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        if (mmio_addr == 16'(32 + 2 * i)) r_regs[i] <= mmio_wdata;
      end
    end
  end

  // Storage needs no reset: clearing the pointers discards the contents.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= mmio_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_tid   <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= mmio_rd_valid;
      if (mmio_rd_valid) begin
        r_rsp_tid  <= mmio_tid;
        r_rsp_data <= w_rd_data;
      end
    end
  end

  assign rd_rsp_valid = r_rsp_valid;
  assign rd_rsp_tid   = r_rsp_tid;
  assign rd_rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_mmio_fifo_regs.sv
// Directed bench for mmio_fifo_regs: header/ID reads, scratch registers, unmapped
// addresses, FIFO fill/overflow/drain/underflow, same-cycle push+pop when full and
// empty, status register (when MMIO_FIFO_STATUS_EN is defined) and mid-read reset.

module tb_mmio_fifo_regs;

  localparam logic [127:0] TB_AFU_ID = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [15:0]  FIFO_A    = 16'h0040;
  localparam logic [15:0]  STAT_A    = 16'h0042;
`ifdef MMIO_FIFO_STATUS_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mmio_wr_valid = 1'b0;
  logic        mmio_rd_valid = 1'b0;
  logic [15:0] mmio_addr = '0;
  logic [8:0]  mmio_tid = '0;
  logic [63:0] mmio_wdata = '0;
  logic        rd_rsp_valid;
  logic [8:0]  rd_rsp_tid;
  logic [63:0] rd_rsp_data;

  int checks = 0;
  int failures = 0;
  logic [63:0] d;

  mmio_fifo_regs #(
    .NUM_REGS  (4),
    .FIFO_DEPTH(16),
    .FIFO_ADDR (FIFO_A),
    .AFU_ID    (TB_AFU_ID)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mmio_wr_valid(mmio_wr_valid),
    .mmio_rd_valid(mmio_rd_valid),
    .mmio_addr    (mmio_addr),
    .mmio_tid     (mmio_tid),
    .mmio_wdata   (mmio_wdata),
    .rd_rsp_valid (rd_rsp_valid),
    .rd_rsp_tid   (rd_rsp_tid),
    .rd_rsp_data  (rd_rsp_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Read: drive on negedge, sample response 1 time unit after the next posedge.
  task automatic rd(input logic [15:0] a, input logic [8:0] t, output logic [63:0] data);
    @(negedge clk);
    mmio_rd_valid = 1'b1;
    mmio_addr     = a;
    mmio_tid      = t;
    @(posedge clk);
    #1;
    mmio_rd_valid = 1'b0;
    check("rsp_valid", 64'(rd_rsp_valid), 64'd1);
    check("rsp_tid", 64'(rd_rsp_tid), 64'(t));
    data = rd_rsp_data;
  endtask

  task automatic wr(input logic [15:0] a, input logic [63:0] wd);
    @(negedge clk);
    mmio_wr_valid = 1'b1;
    mmio_addr     = a;
    mmio_wdata    = wd;
    @(posedge clk);
    #1;
    mmio_wr_valid = 1'b0;
  endtask

  task automatic rw(input logic [15:0] a, input logic [63:0] wd, input logic [8:0] t,
                    output logic [63:0] data);
    @(negedge clk);
    mmio_wr_valid = 1'b1;
    mmio_rd_valid = 1'b1;
    mmio_addr     = a;
    mmio_wdata    = wd;
    mmio_tid      = t;
    @(posedge clk);
    #1;
    mmio_wr_valid = 1'b0;
    mmio_rd_valid = 1'b0;
    check("rw_rsp_valid", 64'(rd_rsp_valid), 64'd1);
    check("rw_rsp_tid", 64'(rd_rsp_tid), 64'(t));
    data = rd_rsp_data;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 64'(rd_rsp_valid), 64'd0);
    check("reset_tid", 64'(rd_rsp_tid), 64'd0);
    check("reset_data", rd_rsp_data, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Header and ID
    rd(16'h0000, 9'd5, d);  check("dfh", d, 64'h1000_0100_0000_0000);
    @(posedge clk); #1;
    check("rsp_one_cycle", 64'(rd_rsp_valid), 64'd0);
    rd(16'h0002, 9'd6, d);  check("afu_lo", d, 64'hFEDC_BA98_7654_3210);
    rd(16'h0004, 9'd7, d);  check("afu_hi", d, 64'h0123_4567_89AB_CDEF);
    rd(16'h0006, 9'd8, d);  check("rsvd6", d, 64'd0);
    rd(16'h0008, 9'd9, d);  check("rsvd8", d, 64'd0);

    // Scratch registers and unmapped space
    wr(16'h0022, 64'hDEAD_BEEF);
    rd(16'h0022, 9'd10, d); check("scratch1", d, 64'hDEAD_BEEF);
    rd(16'h0020, 9'd11, d); check("scratch0", d, 64'd0);
    rd(16'h0100, 9'd12, d); check("unmapped", d, 64'd0);
    wr(16'h0026, 64'h1122_3344_5566_7788);
    rd(16'h0026, 9'd13, d); check("scratch3", d, 64'h1122_3344_5566_7788);
    wr(16'h0028, 64'hFFFF);
    rd(16'h0028, 9'd14, d); check("past_last_reg", d, 64'd0);
    rd(16'h0023, 9'd15, d); check("odd_addr", d, 64'd0);
    wr(16'h0000, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(16'h0000, 9'd16, d); check("dfh_ro", d, 64'h1000_0100_0000_0000);
    wr(16'h0006, 64'h55);
    rd(16'h0006, 9'd17, d); check("rsvd6_ro", d, 64'd0);

    // Same-cycle write+read returns the old value
    rw(16'h0022, 64'hCAFE, 9'd18, d); check("rw_old", d, 64'hDEAD_BEEF);
    rd(16'h0022, 9'd19, d); check("rw_new", d, 64'hCAFE);

    // Fill, overflow, drain, underflow
    for (int i = 1; i <= 17; i++) wr(FIFO_A, 64'(i));
    rd(STAT_A, 9'd20, d);   check("stat_full_ovf", d, STATUS_EN ? 64'h1_0010 : 64'd0);
    for (int i = 1; i <= 16; i++) begin
      rd(FIFO_A, 9'(i), d); check("pop_order", d, 64'(i));
    end
    rd(FIFO_A, 9'd21, d);   check("pop_empty", d, 64'd0);
    rd(STAT_A, 9'd22, d);   check("stat_unf", d, STATUS_EN ? 64'h3_0000 : 64'd0);
    wr(STAT_A, 64'h3_0000);
    rd(STAT_A, 9'd23, d);   check("stat_w1c", d, 64'd0);

    // Full: same-cycle push+pop
    for (int i = 1; i <= 16; i++) wr(FIFO_A, 64'(100 + i));
    rw(FIFO_A, 64'd99, 9'd24, d); check("full_rw_pop", d, 64'd101);
    rd(STAT_A, 9'd25, d);   check("stat_full_rw", d, STATUS_EN ? 64'h10 : 64'd0);
    for (int i = 2; i <= 16; i++) begin
      rd(FIFO_A, 9'(i), d); check("full_rw_order", d, 64'(100 + i));
    end
    rd(FIFO_A, 9'd26, d);   check("pushed_last", d, 64'd99);

    // Empty: same-cycle push+pop
    rw(FIFO_A, 64'd55, 9'd27, d); check("empty_rw_pop", d, 64'd0);
    rd(STAT_A, 9'd28, d);   check("stat_empty_rw", d, STATUS_EN ? 64'h2_0001 : 64'd0);
    rd(FIFO_A, 9'd29, d);   check("empty_rw_push", d, 64'd55);
    wr(STAT_A, 64'h3_0000);

    // Reset during a pending read
    for (int i = 1; i <= 3; i++) wr(FIFO_A, 64'(200 + i));
    rd(STAT_A, 9'd30, d);   check("stat_three", d, STATUS_EN ? 64'h3 : 64'd0);
    @(negedge clk);
    mmio_rd_valid = 1'b1;
    mmio_addr     = FIFO_A;
    mmio_tid      = 9'd31;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    mmio_rd_valid = 1'b0;
    check("rst_no_rsp", 64'(rd_rsp_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_no_rsp", 64'(rd_rsp_valid), 64'd0);
    rd(16'h0022, 9'd32, d); check("rst_scratch", d, 64'd0);
    rd(STAT_A, 9'd33, d);   check("rst_count", d, 64'd0);
    rd(FIFO_A, 9'd34, d);   check("rst_pop", d, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmio_fifo_regs.md
MMIO_FIFO_REGS -- requirements
Module: mmio_fifo_regs

Interface
REQ-001 The block SHALL have parameter NUM_REGS, default 4, number of 64-bit scratch registers (1..16).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 16, FIFO entries (power of 2, 2..256).
REQ-003 The block SHALL have parameter FIFO_ADDR, default 16'h0040, FIFO push/pop address; status register SHALL sit at FIFO_ADDR+2.
REQ-004 The block SHALL have parameter AFU_ID, default 128'h0, AFU UUID.
REQ-005 The block SHALL have port clk, input, 1, clock.
REQ-006 The block SHALL have port rst, input, 1, reset (asynchronous, active-high).
REQ-007 The block SHALL have port mmio_wr_valid, input, 1, MMIO write strobe.
REQ-008 The block SHALL have port mmio_rd_valid, input, 1, MMIO read strobe.
REQ-009 The block SHALL have port mmio_addr, input, 16, DWORD address.
REQ-010 The block SHALL have port mmio_tid, input, 9, read transaction ID.
REQ-011 The block SHALL have port mmio_wdata, input, 64, write data.
REQ-012 The block SHALL have port rd_rsp_valid, output, 1, read response strobe.
REQ-013 The block SHALL have port rd_rsp_tid, output, 9, echoed TID.
REQ-014 The block SHALL have port rd_rsp_data, output, 64, read data.

Function
REQ-015 Every read SHALL produce exactly one response one cycle after mmio_rd_valid: rd_rsp_valid high for one cycle, rd_rsp_tid equal to the captured mmio_tid.
REQ-016 The read map SHALL be: 0x0000 = DFH {4'b0001, 8'b0, 4'b0, 7'b0, 1'b1, 24'b0, 4'b0, 12'b0}; 0x0002 = AFU_ID[63:0]; 0x0004 = AFU_ID[127:64]; 0x0006 and 0x0008 = 0.
REQ-017 Scratch register i SHALL be at 0x0020+2*i for i<NUM_REGS, read/write; writes SHALL take effect the next cycle.
REQ-018 A write to FIFO_ADDR SHALL push mmio_wdata if not full; if full, data SHALL be dropped and sticky ovf set.
REQ-019 A read of FIFO_ADDR SHALL pop the head and return it; if empty, it SHALL return 0, leave state unchanged and set sticky unf.
REQ-020 FIFO ordering SHALL be first-in first-out, pointers wrapping modulo FIFO_DEPTH; count width SHALL be $clog2(FIFO_DEPTH)+1.
REQ-021 When push and pop occur in the same cycle while not empty, both SHALL succeed and count stays; when full, both SHALL succeed (pop frees the slot); when empty, pop SHALL return 0 and set unf while push succeeds.
REQ-022 Unmapped addresses SHALL read 0 and ignore writes; writes to 0x0000-0x0008 SHALL be ignored.
REQ-023 Simultaneous mmio_wr_valid and mmio_rd_valid SHALL both be serviced, with the read returning pre-write register contents.

Reset
REQ-024 While rst is high: rd_rsp_valid=0, rd_rsp_tid=0, rd_rsp_data=0, all scratch registers 0, FIFO pointers/count 0, ovf=unf=0.
REQ-025 Reset mid-operation SHALL discard all FIFO contents and any pending response, with no response issued after reset release.

Configuration
REQ-026 With MMIO_FIFO_STATUS_EN defined, FIFO_ADDR+2 SHALL read {46'b0, unf, ovf, count[15:0] zero-extended} (ovf bit 16, unf bit 17) and writes SHALL clear ovf/unf where wdata bit is 1 (W1C).
REQ-027 Without MMIO_FIFO_STATUS_EN, FIFO_ADDR+2 SHALL behave as unmapped, and the sticky flags SHALL be omitted from the design.

Verification
REQ-028 Reset, read 0x0000 tid=5 -> next cycle rd_rsp_valid=1, tid=5, data=64'h1000_0100_0000_0000.
REQ-029 Write 0x0022=64'hDEAD_BEEF, read 0x0022 -> DEAD_BEEF; read 0x0020 -> 0; read 0x0100 -> 0.
REQ-030 Push 1..16 to 0x0040, push 17 -> status count=16, ovf=1; 16 pops -> 1..16 in order; 17th pop -> 0, unf=1.
REQ-031 FIFO full, same-cycle push 99 and pop -> pop returns oldest, count stays 16, no ovf; 99 emerges last.
REQ-032 Write status 64'h3_0000 -> ovf=unf=0; macro undefined -> status read 0.
REQ-033 Push 3 entries, assert rst mid-read -> no rd_rsp_valid, count=0, subsequent pop returns 0.
